// File: rtl/number_pkg.sv
// Shared constants for the credit display path: FSM states, value range and 7-segment fonts.
// Fonts are active-high, bit order g..a; polarity is applied by the decoder.
package number_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int unsigned NUM_W    = 7;
  localparam logic [6:0]  NUM_MAX  = 7'd99;
  localparam logic [6:0]  NUM_BASE = 7'd10;
  localparam logic [6:0]  KEY_STEP = 7'd10;
  localparam logic [6:0]  KEY_MAX  = 7'd90;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] seg_polar(input logic [6:0] s, input bit active_low);
    return active_low ? ~s : s;
  endfunction

endpackage

// File: rtl/number_decoder_if.sv
// Request/result bundle between the credit logic and the number decoder.
interface number_decoder_if;
  logic       start;
  logic [6:0] number;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [6:0] HEX1;
  logic [6:0] HEX0;

  modport master (
    output start, number,
    input  busy, done, overflow, tens, ones, HEX1, HEX0
  );

  modport slave (
    input  start, number,
    output busy, done, overflow, tens, ones, HEX1, HEX0
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD digit to 7-segment pattern (g..a), with blank and dash overrides.
module seg7_decode
  import number_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  logic [6:0] pattern;

  // Dash wins over blank so an overflow never shows an empty tens digit.
  assign pattern = dash_i  ? SEG_DASH  :
                   blank_i ? SEG_BLANK : seg_digit(digit_i);

  assign seg_o = seg_polar(pattern, SEG_ACTIVE_LOW);

endmodule

// File: rtl/number_decoder.sv
// Binary 0..99 to BCD tens/ones by repeated subtraction, with registered 7-segment outputs.
// done pulses floor(n/10)+2 cycles after start (2 cycles for n>99); start is ignored outside IDLE.
module number_decoder
  import number_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW     = 1'b1,
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  number_decoder_if.slave  bus
);

  localparam logic [6:0] HEX0_RST = seg_polar(SEG_0, SEG_ACTIVE_LOW);
  localparam logic [6:0] HEX1_RST = seg_polar(BLANK_LEADING_ZERO ? SEG_BLANK : SEG_0,
                                              SEG_ACTIVE_LOW);

  state_t     state_q, state_d;
  logic [6:0] work_q, work_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       overflow_q, overflow_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [6:0] hex1_q, hex1_d;
  logic [6:0] hex0_q, hex0_d;

  logic       div_ovf;
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;

  // work only ever decreases, so the range test is meaningful on the first DIV cycle only.
  assign div_ovf = (work_q > NUM_MAX);

  seg7_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_tens (
    .digit_i (tcnt_q),
    .blank_i (BLANK_LEADING_ZERO && (tcnt_q == 4'd0)),
    .dash_i  (div_ovf),
    .seg_o   (seg_tens)
  );

  seg7_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_ones (
    .digit_i (work_q[3:0]),
    .blank_i (1'b0),
    .dash_i  (div_ovf),
    .seg_o   (seg_ones)
  );

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    tcnt_d     = tcnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    hex1_d     = hex1_q;
    hex0_d     = hex0_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d  = bus.number;
          tcnt_d  = 4'd0;
          busy_d  = 1'b1;
          state_d = DIV;
        end
      end
      DIV: begin
        if (div_ovf || (work_q < NUM_BASE)) begin
          // Result registers load on entry to FINISH so done and data appear together.
          state_d    = FINISH;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          overflow_d = div_ovf;
          tens_d     = div_ovf ? 4'hF : tcnt_q;
          ones_d     = div_ovf ? 4'hF : work_q[3:0];
          hex1_d     = seg_tens;
          hex0_d     = seg_ones;
        end else begin
          work_d = work_q - NUM_BASE;
          tcnt_d = tcnt_q + 4'd1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      work_q     <= '0;
      tcnt_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      tens_q     <= '0;
      ones_q     <= '0;
      hex1_q     <= HEX1_RST;
      hex0_q     <= HEX0_RST;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      tcnt_q     <= tcnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      hex1_q     <= hex1_d;
      hex0_q     <= hex0_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.tens     = tens_q;
  assign bus.ones     = ones_q;
  assign bus.HEX1     = hex1_q;
  assign bus.HEX0     = hex0_q;

endmodule

// File: tb/tb_number_decoder.sv
// Directed bench for number_decoder: scoreboard of expected results checked on each done pulse.
module tb_number_decoder;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  number_decoder_if bus ();

  number_decoder #(
    .SEG_ACTIVE_LOW     (1'b1),
    .BLANK_LEADING_ZERO (1'b1)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  typedef struct {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       ovf;
    logic [6:0] hex1;
    logic [6:0] hex0;
    int         due;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Active-high g..a font, inverted below for the active-low board.
  function automatic logic [6:0] font(input int d);
    logic [6:0] f;
    case (d)
      0: f = 7'h3F; 1: f = 7'h06; 2: f = 7'h5B; 3: f = 7'h4F; 4: f = 7'h66;
      5: f = 7'h6D; 6: f = 7'h7D; 7: f = 7'h07; 8: f = 7'h7F; 9: f = 7'h6F;
      default: f = 7'h00;
    endcase
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int n);
    exp_t e;
    if (n > 99) begin
      e.tens = 4'hF; e.ones = 4'hF; e.ovf = 1'b1;
      e.hex1 = ~7'h40; e.hex0 = ~7'h40;
      e.due  = cyc + 2;
    end else begin
      e.tens = 4'(n / 10); e.ones = 4'(n % 10); e.ovf = 1'b0;
      e.hex1 = (n / 10 == 0) ? 7'h7F : ~font(n / 10);
      e.hex0 = ~font(n % 10);
      e.due  = cyc + n / 10 + 2;
    end
    sb.push_back(e);
  endtask

  task automatic pulse(input int n);
    @(negedge clk);
    bus.number = 7'(n);
    bus.start  = 1'b1;
    push_exp(n);
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy || bus.done) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_time"}, 32'(n < 60), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_ovf"},  32'(bus.overflow), 32'd0);
    chk({tag, "_tens"}, 32'(bus.tens), 32'd0);
    chk({tag, "_ones"}, 32'(bus.ones), 32'd0);
    chk({tag, "_hex1"}, 32'(bus.HEX1), 32'h7F);
    chk({tag, "_hex0"}, 32'(bus.HEX0), 32'h40);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.done) begin
      chk("done_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("latency",  32'(cyc), 32'(e.due));
        chk("tens",     32'(bus.tens), 32'(e.tens));
        chk("ones",     32'(bus.ones), 32'(e.ones));
        chk("overflow", 32'(bus.overflow), 32'(e.ovf));
        chk("hex1",     32'(bus.HEX1), 32'(e.hex1));
        chk("hex0",     32'(bus.HEX0), 32'(e.hex0));
      end
    end
  end

  initial begin
    int n;
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.number = 7'd0;
    #1 reset = 1'b0;
    #2 chk_reset_vals("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    pulse(47);  wait_idle("d47");
    pulse(0);   wait_idle("d0");
    pulse(99);  wait_idle("d99");
    pulse(90);  wait_idle("d90");
    pulse(120); wait_idle("d120");
    pulse(5);   wait_idle("d5");

    // Start during FINISH is dropped; start on the following IDLE cycle is taken.
    @(negedge clk);
    bus.number = 7'd23;
    bus.start  = 1'b1;
    push_exp(23);
    @(negedge clk);
    bus.start  = 1'b0;
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("finish_seen", 32'(n < 40), 32'd1);
    bus.number = 7'd77;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.number = 7'd12;
    push_exp(12);
    @(negedge clk);
    bus.start  = 1'b0;
    wait_idle("b2b");

    // Re-pulsed start and a changing number during DIV must not disturb the result.
    @(negedge clk);
    bus.number = 7'd50;
    bus.start  = 1'b1;
    push_exp(50);
    @(negedge clk);
    bus.number = 7'd30;
    chk("busy_div",  32'(bus.busy), 32'd1);
    chk("hold_tens", 32'(bus.tens), 32'd1);
    chk("hold_ones", 32'(bus.ones), 32'd2);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.number = 7'd99;
    @(negedge clk);
    bus.number = 7'd3;
    wait_idle("d50");

    // Reset in the middle of dividing 80 aborts silently.
    pulse(80);
    repeat (3) @(negedge clk);
    chk("busy_before_abort", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    sb.delete();
    chk_reset_vals("abort");
    repeat (3) @(negedge clk);
    chk("done_in_reset", 32'(bus.done), 32'd0);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_done_after_abort", 32'(bus.done), 32'd0);
    chk("tens_after_abort",    32'(bus.tens), 32'd0);
    pulse(10);  wait_idle("d10");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/number_decoder.md
NUMBER_DECODER -- requirements
Module: number_decoder

Interface
REQ-001 SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 = segment lit by driving 0 (DE-board HEX), 0 = lit by driving 1.
REQ-002 SHALL have parameter BLANK_LEADING_ZERO, default 1: 1 = HEX1 blank when tens digit is 0.
REQ-003 SHALL have port CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to decode number.
REQ-006 SHALL have port number  input  7  binary credit value 0..99, the multiples of 10 from the key encoder included.
REQ-007 SHALL have port busy  output  1  conversion in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when tens/ones/HEX outputs are updated.
REQ-009 SHALL have port overflow  output  1  last captured number exceeded 99.
REQ-010 SHALL have port tens  output  4  BCD tens digit of last result.
REQ-011 SHALL have port ones  output  4  BCD ones digit of last result.
REQ-012 SHALL have port HEX1  output  7  tens display, segments g..a.
REQ-013 SHALL have port HEX0  output  7  ones display, segments g..a.

Function
REQ-014 SHALL implement FSM with states IDLE, DIV, FINISH.
REQ-015 IDLE: busy=0; on start=1, SHALL capture number into a 7-bit work register, clear the tens counter, and go to DIV.
REQ-016 DIV: busy=1; captured value >99 SHALL go to FINISH with overflow flagged; else work>=10 SHALL subtract 10 and increment the tens counter, staying in DIV; else SHALL go to FINISH.
REQ-017 FINISH: SHALL load tens, ones (=work), overflow and HEX registers, assert done for exactly one cycle, and return to IDLE.
REQ-018 Latency: done SHALL assert floor(n/10)+2 cycles after the start cycle for n<=99, and 2 cycles for n>99.
REQ-019 start while busy=1 or in FINISH SHALL be ignored; number changes after capture SHALL NOT affect the result.
REQ-020 start asserted on the cycle FINISH returns to IDLE SHALL be accepted on that IDLE cycle.
REQ-021 Outputs tens/ones/overflow/HEX SHALL hold their value between FINISH cycles (registered, no glitching during DIV).
REQ-022 Overflow result: tens=ones=4'hF, HEX1 and HEX0 SHALL show dash (segment g only).
REQ-023 HEX1 SHALL show blank (no segments lit) when tens=0 and BLANK_LEADING_ZERO=1; HEX0 SHALL always show a digit.
REQ-024 Tens counter SHALL be 4 bits; max value 9 for valid inputs, no wrap possible.

Reset
REQ-025 reset=0 SHALL immediately force IDLE, busy=0, done=0, overflow=0, tens=0, ones=0, work=0.
REQ-026 Under reset, HEX0 SHALL show "0"; HEX1 SHALL be blank when BLANK_LEADING_ZERO=1, else show "0".
REQ-027 Reset mid-conversion SHALL abort without a done pulse; first start after release SHALL decode normally.

Structure
REQ-028 FSM state enum, 7-segment digit patterns 0..9, blank and dash constants SHALL live in shared package number_pkg, which the key encoder also uses for its value range constants.
REQ-029 BCD-to-7-segment mapping SHALL be one combinational sub-module seg7_decode, instantiated twice, applying SEG_ACTIVE_LOW polarity.

Verification
REQ-030 Bench SHALL check: start with number=47 -> done 6 cycles later, tens=4, ones=7, HEX1="4", HEX0="7".
REQ-031 Bench SHALL check: number=0 -> done 2 cycles later, tens=0, ones=0, HEX1 blank, HEX0="0".
REQ-032 Bench SHALL check: number=99 -> done 11 cycles later, tens=9, ones=9; number=90 -> tens=9, ones=0.
REQ-033 Bench SHALL check: number=120 -> done 2 cycles later, overflow=1, tens=ones=F, both HEX show dash; next valid start clears overflow.
REQ-034 Bench SHALL check: start with 50, re-pulse start with 30 and change number during DIV -> single done, tens=5, ones=0.
REQ-035 Bench SHALL check: reset low during DIV of 80 -> no done, all outputs at reset values; then start with 10 -> tens=1, ones=0.
